// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave local-controller and serial-line signal bundle
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] slaveDataToSend;
    logic                  txLoad;
    logic                  txReady;
    logic [DATA_WIDTH-1:0] slaveDataReceived;
    logic                  rxValid;
    logic                  frameError;
    logic                  busy;
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;

    modport slave (
        input  slaveDataToSend, txLoad, SCLK, CS, MOSI,
        output txReady, slaveDataReceived, rxValid, frameError, busy, MISO
    );

    modport master (
        output slaveDataToSend, txLoad, SCLK, CS, MOSI,
        input  txReady, slaveDataReceived, rxValid, frameError, busy, MISO
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI slave, LSB first, sample on SCLK fall
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_fall, cs_fall, cs_rise;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  tx_hold_q, tx_hold_d;
    logic                   tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0]  rx_word_q, rx_word_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   miso_q, miso_d;

    logic [DATA_WIDTH-1:0]  load_word, rx_shift, tx_shift;
    logic                   consume, accept;

    // Idle levels in reset so that releasing reset never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;

    assign load_word = tx_full_q ? tx_hold_q : '0;
    assign rx_shift  = {mosi_s, rx_q[DATA_WIDTH-1:1]};
    assign tx_shift  = tx_q >> 1;
    assign accept    = bus.txLoad & ~tx_full_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            tx_hold_q   <= '0;
            tx_full_q   <= 1'b0;
            rx_word_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rx_word_d   = rx_word_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        consume     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_d    = load_word;
                    miso_d  = load_word[0];
                    cnt_d   = '0;
                    consume = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // Shift before looking at CS so a frame finishing as CS rises still counts.
                if (sclk_fall) begin
                    rx_d   = rx_shift;
                    tx_d   = tx_shift;
                    miso_d = tx_shift[0];
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        rx_word_d  = rx_shift;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        if (!cs_s) begin
                            tx_d    = load_word;
                            miso_d  = load_word[0];
                            consume = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (cs_rise) begin
                    frame_err_d = (cnt_d != '0);
                    cnt_d       = '0;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame start empties the holder first; a same-cycle load is only taken if it was empty.
        tx_full_d = (tx_full_q & ~consume) | accept;
        tx_hold_d = accept ? bus.slaveDataToSend : tx_hold_q;
    end

    assign bus.txReady           = ~tx_full_q;
    assign bus.slaveDataReceived = rx_word_q;
    assign bus.rxValid           = rx_valid_q;
    assign bus.frameError        = frame_err_q;
    assign bus.busy              = (state_q == ACTIVE);
    assign bus.MISO              = miso_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed table-driven bench for spi_slave
module tb_spi_slave;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   rx_pulses = 0;
    int   fe_pulses = 0;
    logic [7:0] rx_words[$];

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (bus.rxValid === 1'b1) begin
            rx_pulses++;
            rx_words.push_back(bus.slaveDataReceived);
        end
        if (bus.frameError === 1'b1) fe_pulses++;
    end

    typedef struct {
        bit         do_load;
        logic [7:0] tx_word;
        logic [7:0] mosi_word;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        @(negedge clk);
        bus.txLoad = 1'b1;
        bus.slaveDataToSend = w;
        @(negedge clk);
        bus.txLoad = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.CS = 1'b0;
    endtask

    task automatic cs_high();
        @(negedge clk);
        bus.CS = 1'b1;
    endtask

    // Returns on the cycle the final SCLK fall of the range is driven.
    task automatic send_bits(input logic [7:0] w, input int first, input int last,
                             output logic [7:0] m);
        m = '0;
        for (int i = first; i <= last; i++) begin
            repeat (8) @(negedge clk);
            bus.SCLK = 1'b1;
            bus.MOSI = w[i];
            repeat (8) @(negedge clk);
            m[i] = bus.MISO;
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk1({tag, "_txready"}, bus.txReady, 1'b1);
        chk8({tag, "_rxdata"}, bus.slaveDataReceived, 8'h00);
        chk1({tag, "_miso"}, bus.MISO, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_rxvalid"}, bus.rxValid, 1'b0);
        chk1({tag, "_frameerr"}, bus.frameError, 1'b0);
    endtask

    initial begin
        logic [7:0] m_a, m_b, m_c;
        int rx0, fe0;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};

        reset = 1'b0;
        bus.SCLK = 1'b0;
        bus.CS = 1'b1;
        bus.MOSI = 1'b0;
        bus.txLoad = 1'b0;
        bus.slaveDataToSend = 8'h00;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.SCLK = ~bus.SCLK;
            bus.CS   = ~bus.CS;
            bus.MOSI = ~bus.MOSI;
        end
        @(negedge clk);
        check_idle_outputs("reset_held");
        bus.SCLK = 1'b0;
        bus.CS = 1'b1;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_outputs("reset_release");
        chki("reset_rx_pulses", rx_pulses, 0);
        chki("reset_fe_pulses", fe_pulses, 0);

        for (int v = 0; v < 5; v++) begin
            rx0 = rx_pulses;
            fe0 = fe_pulses;
            if (vecs[v].do_load) begin
                load(vecs[v].tx_word);
                chk1("vec_txready_after_load", bus.txReady, 1'b0);
            end
            cs_low();
            send_bits(vecs[v].mosi_word, 0, 7, m_a);
            chk1("vec_busy_in_frame", bus.busy, 1'b1);
            chk1("vec_txready_after_start", bus.txReady, 1'b1);
            @(negedge clk);
            chk1("vec_lat1", bus.rxValid, 1'b0);
            @(negedge clk);
            chk1("vec_lat2", bus.rxValid, 1'b0);
            @(negedge clk);
            chk1("vec_lat3", bus.rxValid, 1'b1);
            chk8("vec_rxdata_at_valid", bus.slaveDataReceived, vecs[v].exp_rx);
            @(negedge clk);
            chk1("vec_lat4", bus.rxValid, 1'b0);
            cs_high();
            repeat (8) @(negedge clk);
            chk8("vec_miso_word", m_a, vecs[v].exp_miso);
            chk8("vec_rxdata", bus.slaveDataReceived, vecs[v].exp_rx);
            chki("vec_rx_pulses", rx_pulses - rx0, 1);
            chki("vec_fe_pulses", fe_pulses - fe0, 0);
            chk1("vec_busy_after", bus.busy, 1'b0);
            chk1("vec_miso_after", bus.MISO, 1'b0);
        end

        rx0 = rx_pulses;
        fe0 = fe_pulses;
        cs_low();
        send_bits(8'h1F, 0, 4, m_a);
        cs_high();
        repeat (8) @(negedge clk);
        chki("abort_fe_pulses", fe_pulses - fe0, 1);
        chki("abort_rx_pulses", rx_pulses - rx0, 0);
        chk8("abort_rxdata_kept", bus.slaveDataReceived, 8'hC3);
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_miso", bus.MISO, 1'b0);

        rx0 = rx_pulses;
        fe0 = fe_pulses;
        load(8'h11);
        cs_low();
        send_bits(8'h81, 0, 3, m_a);
        load(8'h22);
        send_bits(8'h81, 4, 7, m_b);
        send_bits(8'h7E, 0, 7, m_c);
        cs_high();
        repeat (8) @(negedge clk);
        chk8("b2b_miso_first", m_a | m_b, 8'h11);
        chk8("b2b_miso_second", m_c, 8'h22);
        chki("b2b_rx_pulses", rx_pulses - rx0, 2);
        chki("b2b_fe_pulses", fe_pulses - fe0, 0);
        if (rx_words.size() >= 2) begin
            chk8("b2b_rx_first", rx_words[rx_words.size() - 2], 8'h81);
            chk8("b2b_rx_second", rx_words[rx_words.size() - 1], 8'h7E);
        end else begin
            chki("b2b_rx_words_captured", rx_words.size(), 2);
        end
        chk1("b2b_txready", bus.txReady, 1'b1);

        load(8'h55);
        chk1("rej_txready_first", bus.txReady, 1'b0);
        load(8'h66);
        chk1("rej_txready_second", bus.txReady, 1'b0);
        cs_low();
        send_bits(8'h33, 0, 7, m_a);
        cs_high();
        repeat (8) @(negedge clk);
        chk8("rej_miso_word", m_a, 8'h55);
        chk8("rej_rxdata", bus.slaveDataReceived, 8'h33);
        chk1("rej_txready_after", bus.txReady, 1'b1);

        rx0 = rx_pulses;
        fe0 = fe_pulses;
        load(8'h99);
        cs_low();
        send_bits(8'hAA, 0, 2, m_a);
        @(negedge clk);
        reset = 1'b0;
        bus.CS = 1'b1;
        bus.SCLK = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chki("midreset_rx_pulses", rx_pulses - rx0, 0);
        chki("midreset_fe_pulses", fe_pulses - fe0, 0);
        chk1("midreset_busy_after", bus.busy, 1'b0);

        rx0 = rx_pulses;
        load(8'hC3);
        cs_low();
        send_bits(8'h96, 0, 7, m_a);
        cs_high();
        repeat (8) @(negedge clk);
        chk8("post_reset_miso", m_a, 8'hC3);
        chk8("post_reset_rxdata", bus.slaveDataReceived, 8'h96);
        chki("post_reset_rx_pulses", rx_pulses - rx0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
